rr_arbiter16: RTL and testbench
===============================

RR_ARBITER16 -- requirements
Module: rr_arbiter16

Interface
REQ-001 SHALL have parameter: PTR_INIT, 4'd0, requester index where the search starts after reset.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: req  input  16  one request line per requester, level-sensitive.
REQ-005 SHALL have port: enable  input  1  permits new grants when 1.
REQ-006 SHALL have port: gnt_ready  input  1  downstream 16-to-4 encoder stage accepts the current grant.
REQ-007 SHALL have port: gnt_onehot  output  16  registered one-hot grant, the feed for the downstream encoder input.
REQ-008 SHALL have port: gnt_valid  output  1  gnt_onehot holds a valid grant.
REQ-009 SHALL have port, only when ARB_LOCK_EN is defined: lock  input  1  keep the same requester on accept.

Function
REQ-010 SHALL keep a 4-bit pointer ptr; the search order is ptr, ptr+1, ..., 15, 0, ..., ptr-1 (mod 16).
REQ-011 SHALL implement FSM IDLE/GRANT; gnt_valid=1 exactly in GRANT.
REQ-012 IDLE: if enable=1 and req!=0 at a clock edge, SHALL load gnt_onehot with the first set req bit in search order and enter GRANT; latency is one edge (req sampled at edge N, gnt_valid high after edge N).
REQ-013 IDLE with enable=0 or req=0 SHALL stay IDLE with gnt_onehot=16'h0000.
REQ-014 GRANT with gnt_ready=0: gnt_onehot and gnt_valid SHALL stay stable regardless of req or enable changes; a withdrawn request does not revoke the grant.
REQ-015 Accept is gnt_valid=1 and gnt_ready=1 at an edge; ptr SHALL become (granted index+1) mod 16, with 15 wrapping to 0.
REQ-016 On accept with enable=1 and req!=0, SHALL load the next grant in the same edge, searching from the updated ptr, and stay in GRANT (back-to-back, one grant per cycle).
REQ-017 On accept with enable=0 or req=0, SHALL return to IDLE and clear gnt_onehot.
REQ-018 When gnt_valid=1, gnt_onehot SHALL have exactly one bit set; when gnt_valid=0, it SHALL be 16'h0000.
REQ-019 A single active requester SHALL be re-granted on every accept (the search wraps back to it).
REQ-020 enable falling during GRANT SHALL NOT drop the held grant; only the follow-on grant is suppressed.

Reset
REQ-021 While rst_n=0, without waiting for clk: state=IDLE, gnt_valid=0, gnt_onehot=16'h0000, ptr=PTR_INIT.
REQ-022 Reset asserted mid-grant SHALL discard the grant; the grant is not re-presented after reset.
REQ-023 The first grant evaluation after reset release SHALL occur on the first rising clk edge with rst_n=1.

Configuration
REQ-024 Macro ARB_LOCK_EN defined: lock port present; on accept with lock=1 and req[granted index]=1, SHALL grant the same requester again and SHALL NOT change ptr; otherwise REQ-015..017 apply.
REQ-025 Macro ARB_LOCK_EN undefined: no lock port; the pointer always advances per REQ-015.

Verification
REQ-026 Reset with req=16'hFFFF held -> gnt_valid=0 and gnt_onehot=16'h0000 while rst_n=0; the first edge after release gives 16'h0001.
REQ-027 req=16'hFFFF, gnt_ready=1 held -> consecutive grants 0001, 0002, 0004, ..., 8000, then 0001 (wrap).
REQ-028 req=16'h8001, ptr=0, gnt_ready=1 -> grants alternate 0001, 8000, 0001.
REQ-029 req=16'h0010 then req=0 with gnt_ready=0 for 5 cycles -> gnt_onehot=16'h0010 and gnt_valid=1 held for all 5 cycles; after gnt_ready=1 -> IDLE, gnt_onehot=0.
REQ-030 rst_n pulsed low mid-GRANT (gnt_onehot=16'h0100) -> gnt_valid=0 immediately; the next grant for req=16'h0101 is 16'h0001 (ptr=PTR_INIT=0).
REQ-031 ARB_LOCK_EN defined, req=16'h0003, lock=1, gnt_ready=1 -> 0001 granted repeatedly; lock=0 -> next grant 0002.

Source files
------------

// File: rtl/rr_arbiter16.sv
// rr_arbiter16: 16-requester round-robin arbiter with a registered one-hot
// grant held until accepted downstream.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   req[15:0]   level-sensitive request lines
//   enable      permits new grants when 1
//   gnt_ready   downstream stage accepts the current grant
//   lock        (ARB_LOCK_EN only) re-grant the same requester on accept
//   gnt_onehot  registered one-hot grant, zero when no grant is held
//   gnt_valid   gnt_onehot holds a valid grant
//
// Optional feature: define ARB_LOCK_EN to add the lock input.
module rr_arbiter16 #(
    parameter logic [3:0] PTR_INIT = 4'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] req,
    input  logic        enable,
    input  logic        gnt_ready,
`ifdef ARB_LOCK_EN
    input  logic        lock,
`endif
    output logic [15:0] gnt_onehot,
    output logic        gnt_valid
);

    localparam int unsigned N  = 16;
    localparam int unsigned PW = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   ptr, ptr_nxt;
    logic [N-1:0]    gnt_nxt;
    logic [PW-1:0]   gnt_idx;
    logic [PW-1:0]   ptr_adv;
    logic            keep;

    // Isolate the lowest set bit of a vector.
    function automatic logic [N-1:0] lowest(input logic [N-1:0] v);
        return v & (~v + N'(1));
    endfunction

    // First set request at or above p; wrap to the lowest set bit otherwise.
    function automatic logic [N-1:0] pick(input logic [N-1:0] r, input logic [PW-1:0] p);
        logic [N-1:0] upper;
        upper = r & ({N{1'b1}} << p);
        return (|upper) ? lowest(upper) : lowest(r);
    endfunction

    // Binary index of a one-hot vector.
    function automatic logic [PW-1:0] encode(input logic [N-1:0] v);
        logic [PW-1:0] idx;
        idx = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (v[i]) idx = idx | PW'(i);
        end
        return idx;
    endfunction

    always_comb gnt_idx = encode(gnt_onehot);
    always_comb ptr_adv = gnt_idx + PW'(1);

    // Lock holds the current grant as long as its request is still asserted.
`ifdef ARB_LOCK_EN
    always_comb keep = lock & req[gnt_idx];
`else
    always_comb keep = 1'b0;
`endif

    // Next-state, pointer and grant selection.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        gnt_nxt   = gnt_onehot;
        case (state)
            IDLE: begin
                gnt_nxt = '0;
                if (enable && (|req)) begin
                    gnt_nxt   = pick(req, ptr);
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (gnt_ready) begin
                    if (!keep) begin
                        ptr_nxt = ptr_adv;
                        if (enable && (|req)) begin
                            gnt_nxt = pick(req, ptr_adv);
                        end else begin
                            gnt_nxt   = '0;
                            state_nxt = IDLE;
                        end
                    end
                end
            end
            default: begin
                gnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    // State, pointer and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= PTR_INIT;
            gnt_onehot <= '0;
            gnt_valid  <= 1'b0;
        end else begin
            state      <= state_nxt;
            ptr        <= ptr_nxt;
            gnt_onehot <= gnt_nxt;
            gnt_valid  <= (state_nxt == GRANT);
        end
    end

endmodule

// File: tb/tb_rr_arbiter16.sv
// tb_rr_arbiter16: self-checking bench for rr_arbiter16 with directed
// scenarios and randomized traffic against a behavioural model.
module tb_rr_arbiter16;

    logic        clk;
    logic        rst_n;
    logic [15:0] req;
    logic        enable;
    logic        gnt_ready;
    logic        lock;
    logic [15:0] gnt_onehot;
    logic        gnt_valid;

    int checks = 0;
    int passed = 0;

    // Model state: pointer, whether a grant is held, and which requester.
    int m_ptr;
    bit m_valid;
    int m_idx;

    rr_arbiter16 #(.PTR_INIT(4'd0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .enable     (enable),
        .gnt_ready  (gnt_ready),
`ifdef ARB_LOCK_EN
        .lock       (lock),
`endif
        .gnt_onehot (gnt_onehot),
        .gnt_valid  (gnt_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int search(input logic [15:0] r, input int p);
        for (int k = 0; k < 16; k++) begin
            if (r[(p + k) % 16]) return (p + k) % 16;
        end
        return -1;
    endfunction

    function automatic logic [16:0] expected();
        logic [15:0] g;
        g = m_valid ? (16'(1) << m_idx) : 16'h0000;
        return {m_valid, g};
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_valid = 0; m_idx = 0;
    endtask

    // Advance the model by one clock edge using the current inputs.
    task automatic model_step();
        bit hold;
        if (!m_valid) begin
            if (enable && req != 0) begin
                m_idx = search(req, m_ptr);
                m_valid = 1;
            end
        end else if (gnt_ready) begin
            hold = 0;
`ifdef ARB_LOCK_EN
            hold = lock && req[m_idx];
`endif
            if (!hold) begin
                m_ptr = (m_idx + 1) % 16;
                if (enable && req != 0) m_idx = search(req, m_ptr);
                else m_valid = 0;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 0;
        model_reset();
        #2;
        rst_n = 1;
    endtask

    task automatic test_reset();
        req = 16'hFFFF; enable = 1; gnt_ready = 1; lock = 0;
        rst_n = 1;
        #2 rst_n = 0;
        model_reset();
        #1;
        checks++;
        if ({gnt_valid, gnt_onehot} !== 17'h0) $display("FAIL reset_async got %b/%h want 0/0000", gnt_valid, gnt_onehot);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({gnt_valid, gnt_onehot} !== 17'h0) $display("FAIL reset_held got %b/%h want 0/0000", gnt_valid, gnt_onehot);
            else passed++;
        end
        #2 rst_n = 1;
        tick();
        checks++;
        if ({gnt_valid, gnt_onehot} !== {1'b1, 16'h0001}) $display("FAIL reset_first got %b/%h want 1/0001", gnt_valid, gnt_onehot);
        else passed++;
    endtask

    task automatic test_sweep();
        logic [15:0] want;
        do_reset();
        req = 16'hFFFF; enable = 1; gnt_ready = 1;
        for (int i = 0; i < 17; i++) begin
            tick();
            want = 16'(1) << (i % 16);
            checks++;
            if (gnt_onehot !== want || gnt_valid !== 1'b1) $display("FAIL sweep[%0d] got %b/%h want 1/%h", i, gnt_valid, gnt_onehot, want);
            else passed++;
        end
    endtask

    task automatic test_alternate();
        logic [15:0] seq [3];
        seq[0] = 16'h0001; seq[1] = 16'h8000; seq[2] = 16'h0001;
        do_reset();
        req = 16'h8001; enable = 1; gnt_ready = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (gnt_onehot !== seq[i] || gnt_valid !== 1'b1) $display("FAIL alternate[%0d] got %b/%h want 1/%h", i, gnt_valid, gnt_onehot, seq[i]);
            else passed++;
        end
    endtask

    task automatic test_hold();
        enable = 0; gnt_ready = 1; req = 0;
        tick(); tick();
        req = 16'h0010; enable = 1; gnt_ready = 0;
        tick();
        req = 16'h0000;
        for (int i = 0; i < 5; i++) begin
            enable = i[0];
            tick();
            checks++;
            if (gnt_onehot !== 16'h0010 || gnt_valid !== 1'b1) $display("FAIL hold[%0d] got %b/%h want 1/0010", i, gnt_valid, gnt_onehot);
            else passed++;
        end
        gnt_ready = 1;
        tick();
        checks++;
        if ({gnt_valid, gnt_onehot} !== 17'h0) $display("FAIL hold_release got %b/%h want 0/0000", gnt_valid, gnt_onehot);
        else passed++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 16'h0100; enable = 1; gnt_ready = 0;
        tick();
        checks++;
        if (gnt_onehot !== 16'h0100 || gnt_valid !== 1'b1) $display("FAIL mid_setup got %b/%h want 1/0100", gnt_valid, gnt_onehot);
        else passed++;
        rst_n = 0;
        model_reset();
        #1;
        checks++;
        if ({gnt_valid, gnt_onehot} !== 17'h0) $display("FAIL mid_reset got %b/%h want 0/0000", gnt_valid, gnt_onehot);
        else passed++;
        #1 rst_n = 1;
        req = 16'h0101; gnt_ready = 1;
        tick();
        checks++;
        if (gnt_onehot !== 16'h0001 || gnt_valid !== 1'b1) $display("FAIL mid_after got %b/%h want 1/0001", gnt_valid, gnt_onehot);
        else passed++;
    endtask

    task automatic test_random();
        logic [16:0] want;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0: req = 16'h0;
                1: req = 16'(1) << $urandom_range(0, 15);
                default: req = 16'($urandom);
            endcase
            enable    = ($urandom_range(0, 9) < 8);
            gnt_ready = ($urandom_range(0, 9) < 6);
            lock      = ($urandom_range(0, 3) == 0);
            tick();
            want = expected();
            checks++;
            if ({gnt_valid, gnt_onehot} !== want) $display("FAIL random[%0d] got %b/%h want %b/%h", i, gnt_valid, gnt_onehot, want[16], want[15:0]);
            else passed++;
        end
        lock = 0;
    endtask

`ifdef ARB_LOCK_EN
    task automatic test_lock();
        do_reset();
        req = 16'h0003; enable = 1; gnt_ready = 1; lock = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (gnt_onehot !== 16'h0001 || gnt_valid !== 1'b1) $display("FAIL lock[%0d] got %b/%h want 1/0001", i, gnt_valid, gnt_onehot);
            else passed++;
        end
        lock = 0;
        tick();
        checks++;
        if (gnt_onehot !== 16'h0002 || gnt_valid !== 1'b1) $display("FAIL lock_release got %b/%h want 1/0002", gnt_valid, gnt_onehot);
        else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_sweep();
        test_alternate();
        test_hold();
        test_reset_mid();
`ifdef ARB_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
